// File: rtl/sweep_controller.sv
// sweep_controller
//   Produces the ena step strobes for the X and Y triangle generators of the
//   etch-a-sketch datapath. Each axis has a programmable rate prescaler. A
//   run/pause/step/abort command FSM gates the sweep. An optional frame limit
//   ends the sweep after a fixed number of full X triangle periods.
//
// Parameters
//   N      width of the driven triangle generators (X period = 2*(2**N-1) strobes)
//   DIV_W  prescaler divisor width
//   FR_W   frame-count width
//
// Ports
//   clk     clock, all logic on posedge
//   rst     asynchronous active-low reset
//   start   begin sweep (IDLE) or resume (PAUSE)
//   stop    pause sweep (RUN -> PAUSE)
//   step    one strobe on both axes while paused
//   abort   return to IDLE from any state
//   div_x   X strobe period minus 1, latched on start from IDLE
//   div_y   Y strobe period minus 1, latched on start from IDLE
//   frames  X periods to run, latched on start from IDLE (0 = forever)
//   ena_x   registered one-cycle X step strobe
//   ena_y   registered one-cycle Y step strobe
//   busy    high in RUN or PAUSE
//   done    one-cycle pulse when the frame limit is reached
//   state   IDLE=0, RUN=1, PAUSE=2, DONE=3
module sweep_controller #(
  parameter int N     = 8,
  parameter int DIV_W = 16,
  parameter int FR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             abort,
  input  logic [DIV_W-1:0] div_x,
  input  logic [DIV_W-1:0] div_y,
  input  logic [FR_W-1:0]  frames,
  output logic             ena_x,
  output logic             ena_y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Wide enough to hold frames*PERIOD for the largest frames value.
  localparam int PC_W = FR_W + N + 1;
  localparam logic [PC_W-1:0] PERIOD = PC_W'(2 * ((1 << N) - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_ABORT,
    C_STOP,
    C_STEP,
    C_START
  } cmd_t;

  state_t           st;
  cmd_t             cmd;
  logic [DIV_W-1:0] div_x_q;
  logic [DIV_W-1:0] div_y_q;
  logic [FR_W-1:0]  frames_q;
  logic [DIV_W-1:0] cnt_x;
  logic [DIV_W-1:0] cnt_y;
  logic [PC_W-1:0]  pulse_cnt;
  logic [PC_W-1:0]  pulse_inc;
  logic [PC_W-1:0]  limit;
  logic             hit_x;
  logic             hit_y;
  logic             hit_limit;

  // Only one command is acted on per cycle.
  always_comb begin
    cmd = C_NONE;
    if (abort)      cmd = C_ABORT;
    else if (stop)  cmd = C_STOP;
    else if (step)  cmd = C_STEP;
    else if (start) cmd = C_START;
  end

  always_comb begin
    hit_x     = (cnt_x == div_x_q);
    hit_y     = (cnt_y == div_y_q);
    pulse_inc = pulse_cnt + PC_W'(1);
    limit     = PC_W'(frames_q) * PERIOD;
    // Evaluated against the count this strobe will produce, so the final
    // strobe and the done pulse leave on the same edge.
    hit_limit = (frames_q != '0) && (pulse_inc == limit);
  end

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      ena_x     <= 1'b0;
      ena_y     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_x_q   <= '0;
      div_y_q   <= '0;
      frames_q  <= '0;
      cnt_x     <= '0;
      cnt_y     <= '0;
      pulse_cnt <= '0;
    end else begin
      ena_x <= 1'b0;
      ena_y <= 1'b0;
      done  <= 1'b0;
      case (st)
        IDLE: begin
          if (cmd == C_START) begin
            st        <= RUN;
            busy      <= 1'b1;
            div_x_q   <= div_x;
            div_y_q   <= div_y;
            frames_q  <= frames;
            cnt_x     <= '0;
            cnt_y     <= '0;
            pulse_cnt <= '0;
          end
        end

        RUN: begin
          if (cmd == C_ABORT) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else if (cmd == C_STOP) begin
            st <= PAUSE;
          end else begin
            cnt_x <= hit_x ? '0 : cnt_x + DIV_W'(1);
            cnt_y <= hit_y ? '0 : cnt_y + DIV_W'(1);
            ena_x <= hit_x;
            ena_y <= hit_y;
            if (hit_x) begin
              pulse_cnt <= pulse_inc;
              if (hit_limit) begin
                st   <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end
        end

        PAUSE: begin
          case (cmd)
            C_ABORT: begin
              st   <= IDLE;
              busy <= 1'b0;
            end
            // Step strobes both axes without touching the prescalers.
            C_STEP: begin
              ena_x     <= 1'b1;
              ena_y     <= 1'b1;
              pulse_cnt <= pulse_inc;
              if (hit_limit) begin
                st   <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
            C_START: st <= RUN;
            default: ;
          endcase
        end

        DONE: begin
          st <= IDLE;
        end

        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
module tb_sweep_controller;

  localparam int N      = 8;
  localparam int DIV_W  = 16;
  localparam int FR_W   = 8;
  localparam int PERIOD = 2 * ((1 << N) - 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             step = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] div_x = '0;
  logic [DIV_W-1:0] div_y = '0;
  logic [FR_W-1:0]  frames = '0;
  logic             ena_x;
  logic             ena_y;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int total = 0;
  int bad   = 0;

  // Reference model: sweep position expressed as elapsed run cycles per axis;
  // an axis strobes whenever its elapsed count is a multiple of (div+1).
  int   m_st;       // 0 idle, 1 run, 2 pause, 3 done
  int   m_dx, m_dy, m_fr;
  int   m_nx, m_ny;
  int   m_strobes;
  logic e_x, e_y, e_done;
  int   obs_x;
  logic seen;

  sweep_controller #(.N(N), .DIV_W(DIV_W), .FR_W(FR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .step  (step),
    .abort (abort),
    .div_x (div_x),
    .div_y (div_y),
    .frames(frames),
    .ena_x (ena_x),
    .ena_y (ena_y),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_dx = 0; m_dy = 0; m_fr = 0;
    m_nx = 0; m_ny = 0; m_strobes = 0;
    e_x = 1'b0; e_y = 1'b0; e_done = 1'b0;
  endtask

  task automatic count_strobe();
    m_strobes++;
    if (m_fr != 0 && m_strobes == m_fr * PERIOD) begin
      m_st   = 3;
      e_done = 1'b1;
    end
  endtask

  task automatic model_edge();
    e_x = 1'b0; e_y = 1'b0; e_done = 1'b0;
    case (m_st)
      0: if (!abort && !stop && !step && start) begin
           m_st = 1;
           m_dx = int'(div_x); m_dy = int'(div_y); m_fr = int'(frames);
           m_nx = 0; m_ny = 0; m_strobes = 0;
         end
      1: if (abort) m_st = 0;
         else if (stop) m_st = 2;
         else begin
           m_nx++; m_ny++;
           e_x = (m_nx % (m_dx + 1)) == 0;
           e_y = (m_ny % (m_dy + 1)) == 0;
           if (e_x) count_strobe();
         end
      2: if (abort) m_st = 0;
         else if (stop) ;
         else if (step) begin
           e_x = 1'b1; e_y = 1'b1;
           count_strobe();
         end else if (start) m_st = 1;
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("ena_x", 32'(ena_x), 32'(e_x));
    check("ena_y", 32'(ena_y), 32'(e_y));
    check("done",  32'(done),  32'(e_done));
    check("busy",  32'(busy),  32'(m_st == 1 || m_st == 2));
    check("state", 32'(state), 32'(m_st));
    if (ena_x === 1'b1) obs_x++;
  endtask

  task automatic cmd(input logic s, input logic p, input logic t, input logic a);
    start = s; stop = p; step = t; abort = a;
  endtask

  initial begin
    model_reset();
    obs_x = 0;
    #1 rst = 1'b0;
    #11;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ena",   32'({ena_x, ena_y, busy, done}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: free-running, X every cycle, Y every 4th
    div_x = 16'd0; div_y = 16'd3; frames = 8'd0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    repeat (20) tick();
    check("t1_busy", 32'(busy), 32'd1);
    cmd(0, 0, 0, 1); tick(); cmd(0, 0, 0, 0); tick();

    // 2: one frame, done with the 510th X strobe
    div_x = 16'd0; div_y = 16'($urandom_range(0, 7)); frames = 8'd1;
    obs_x = 0; seen = 1'b0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    for (int i = 0; i < 700 && !seen; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        check("t2_count", 32'(obs_x), 32'(PERIOD));
      end
    end
    check("t2_done_seen", 32'(seen), 32'd1);
    tick();
    check("t2_idle", 32'(state), 32'd0);

    // 3: pause, three steps, resume from held prescaler
    div_x = 16'd4; div_y = 16'd2; frames = 8'd0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    repeat (7) tick();
    cmd(0, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    obs_x = 0;
    repeat (3) begin
      cmd(0, 0, 1, 0); tick(); cmd(0, 0, 0, 0); tick();
    end
    check("t3_steps", 32'(obs_x), 32'd3);
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    repeat (15) tick();

    // 4: command priority and DONE ignoring start
    cmd(1, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    check("t4_start_stop", 32'(state), 32'd2);
    cmd(1, 0, 0, 0); tick();
    cmd(0, 1, 0, 1); tick(); cmd(0, 0, 0, 0);
    check("t4_abort_stop", 32'(state), 32'd0);
    div_x = 16'd0; frames = 8'd1; seen = 1'b0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    for (int i = 0; i < 700 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check("t4_done_seen", 32'(seen), 32'd1);
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    check("t4_done_start", 32'(state), 32'd0);
    tick();

    // 5: asynchronous reset mid-run
    div_x = 16'd0; div_y = 16'd1; frames = 8'd0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    check("t5_async_out", 32'({ena_x, ena_y, busy}), 32'd0);
    check("t5_async_state", 32'(state), 32'd0);
    model_reset();
    @(posedge clk); #3 rst = 1'b1;
    repeat (4) tick();

    // 6: limit reached by stepping from PAUSE
    div_x = 16'd1; div_y = 16'($urandom_range(0, 9)); frames = 8'd2;
    obs_x = 0; seen = 1'b0;
    cmd(1, 0, 0, 0); tick(); cmd(0, 0, 0, 0);
    repeat (2030) tick();
    cmd(0, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    check("t6_paused", 32'(state), 32'd2);
    cmd(0, 0, 1, 0);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        check("t6_state_done", 32'(state), 32'd3);
      end
    end
    cmd(0, 0, 0, 0);
    check("t6_done_seen", 32'(seen), 32'd1);
    check("t6_count", 32'(obs_x), 32'(2 * PERIOD));
    tick();

    // random command soup
    for (int i = 0; i < 400; i++) begin
      if (m_st == 0) begin
        div_x  = 16'($urandom_range(0, 5));
        div_y  = 16'($urandom_range(0, 5));
        frames = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
      end
      cmd($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
      tick();
    end
    cmd(0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
